rtc_display_sequencer: RTL and testbench

Controller sitting between the RTC bus controller and `Interfaz`. Every `REFRESH_FRAMES` video frames it requests a read of the eight time/date registers, captures the returned bytes, then replays them to `Interfaz` on `datoRTC` framed by `inicioSecuencia`, aligned to a frame boundary, and closes with a one-cycle `resetSync` pulse. It replaces the hand-timed load sequence with a deterministic, frame-synchronous scheduler.

---
 rtl/rtc_display_sequencer_if.sv | 25 ++
 rtl/rtc_display_sequencer.sv | 157 +++++++++++++++
 tb/tb_rtc_display_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_display_sequencer_if.sv
// Signal bundle between the RTC display sequencer, the RTC bus controller and Interfaz.
// master is the sequencer side; slave is the surrounding system.
interface rtc_display_sequencer_if;
    logic       enable;
    logic       frame_tick;
    logic       rtc_busy;
    logic       rtc_read_req;
    logic       rtc_dato_valid;
    logic [7:0] rtc_dato;
    logic       inicioSecuencia;
    logic [7:0] datoRTC;
    logic       resetSync;
    logic       update_done;
    logic       seq_error;

    modport master (
        input  enable, frame_tick, rtc_busy, rtc_dato_valid, rtc_dato,
        output rtc_read_req, inicioSecuencia, datoRTC, resetSync, update_done, seq_error
    );

    modport slave (
        output enable, frame_tick, rtc_busy, rtc_dato_valid, rtc_dato,
        input  rtc_read_req, inicioSecuencia, datoRTC, resetSync, update_done, seq_error
    );
endinterface

// File: rtl/rtc_display_sequencer.sv
// Frame-synchronous scheduler: reads the eight RTC time/date bytes every REFRESH_FRAMES frames
// and replays them to Interfaz inside a LEAD/TAIL-padded load window. LEAD and TAIL must be >= 1.
module rtc_display_sequencer #(
    parameter int REFRESH_FRAMES = 60,
    parameter int LEAD           = 10,
    parameter int TAIL           = 3,
    parameter int TIMEOUT        = 255
) (
    input logic                     clk,
    input logic                     reset,
    rtc_display_sequencer_if.master bus
);

    localparam int PHASE_MAX = (LEAD > TAIL) ? LEAD : TAIL;
    localparam int FW        = $clog2(REFRESH_FRAMES + 1);
    localparam int TW        = $clog2(TIMEOUT + 1);
    localparam int PW        = $clog2(PHASE_MAX + 1);

    localparam logic [FW-1:0] FRAME_LAST   = FW'(REFRESH_FRAMES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] LEAD_LAST    = PW'(LEAD - 1);
    localparam logic [PW-1:0] TAIL_LAST    = PW'(TAIL - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAPTURE,
        ST_WAIT_TICK,
        ST_LEAD,
        ST_DATA,
        ST_TAIL,
        ST_SYNC
    } state_t;

    state_t        state;
    logic [FW-1:0] frame_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [PW-1:0] phase_cnt;
    logic [2:0]    byte_idx;
    logic [7:0]    buffer [8];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            frame_cnt   <= '0;
            timeout_cnt <= '0;
            phase_cnt   <= '0;
            byte_idx    <= '0;
            // NOTE: the capture buffer is small and must read as zero after reset, so it is
            // cleared here like any other register rather than left as uninitialised storage.
            for (int i = 0; i < 8; i++) buffer[i] <= '0;
            bus.rtc_read_req    <= 1'b0;
            bus.inicioSecuencia <= 1'b0;
            bus.datoRTC         <= '0;
            bus.resetSync       <= 1'b0;
            bus.update_done     <= 1'b0;
            bus.seq_error       <= 1'b0;
        end else begin
            bus.rtc_read_req <= 1'b0;
            bus.resetSync    <= 1'b0;
            bus.update_done  <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (!bus.enable) begin
                        frame_cnt <= '0;
                    end else if (bus.frame_tick) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt   <= '0;
                            timeout_cnt <= '0;
                            state       <= ST_REQ;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                ST_REQ: begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                    if (timeout_cnt == TIMEOUT_LAST) begin
                        bus.seq_error <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (!bus.rtc_busy) begin
                        bus.rtc_read_req <= 1'b1;
                        byte_idx         <= '0;
                        state            <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                    if (bus.rtc_dato_valid) begin
                        buffer[byte_idx] <= bus.rtc_dato;
                        byte_idx         <= byte_idx + 1'b1;
                    end
                    // A last byte arriving on the final timeout cycle still counts as success.
                    if (bus.rtc_dato_valid && byte_idx == 3'd7) begin
                        state <= ST_WAIT_TICK;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        bus.seq_error <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end

                ST_WAIT_TICK: begin
                    if (bus.frame_tick) begin
                        bus.inicioSecuencia <= 1'b1;
                        bus.datoRTC         <= '0;
                        phase_cnt           <= '0;
                        state               <= ST_LEAD;
                    end
                end

                ST_LEAD: begin
                    if (phase_cnt == LEAD_LAST) begin
                        bus.datoRTC <= buffer[0];
                        byte_idx    <= '0;
                        state       <= ST_DATA;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (byte_idx == 3'd7) begin
                        bus.datoRTC <= '0;
                        phase_cnt   <= '0;
                        state       <= ST_TAIL;
                    end else begin
                        bus.datoRTC <= buffer[byte_idx + 3'd1];
                        byte_idx    <= byte_idx + 1'b1;
                    end
                end

                ST_TAIL: begin
                    if (phase_cnt == TAIL_LAST) begin
                        bus.inicioSecuencia <= 1'b0;
                        bus.resetSync       <= 1'b1;
                        bus.update_done     <= 1'b1;
                        bus.seq_error       <= 1'b0;
                        state               <= ST_SYNC;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                ST_SYNC: begin
                    frame_cnt <= '0;
                    state     <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_display_sequencer.sv
// Self-checking bench for rtc_display_sequencer: table of refresh scenarios plus a
// mid-stream reset sequence; captured bytes are tracked through a scoreboard queue.
module tb_rtc_display_sequencer;

    localparam int REFRESH_FRAMES = 2;
    localparam int LEAD           = 10;
    localparam int TAIL           = 3;
    localparam int TIMEOUT        = 255;
    localparam int STREAM_LEN     = LEAD + TAIL + 11;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    rtc_display_sequencer_if bus();

    rtc_display_sequencer #(
        .REFRESH_FRAMES(REFRESH_FRAMES),
        .LEAD          (LEAD),
        .TAIL          (TAIL),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:7][7:0] bytes;
        int              n_bytes;
        int              gap;
        int              busy;
        bit              spurious;
        bit              tick_on_last;
        bit              exp_error;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] sb_q [$];
    int         checks    = 0;
    int         errors    = 0;
    int         cyc       = 0;
    int         inicio_hi = 0;
    int         sync_hi   = 0;
    logic       exp_err   = 1'b0;

    always @(negedge clk) begin
        if (bus.inicioSecuencia === 1'b1) inicio_hi++;
        if (bus.resetSync === 1'b1) sync_hi++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0d required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_tick(output int t);
        t = cyc;
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},    32'(bus.rtc_read_req),    0);
        check({tag, "_inicio"}, 32'(bus.inicioSecuencia), 0);
        check({tag, "_dato"},   32'(bus.datoRTC),         0);
        check({tag, "_sync"},   32'(bus.resetSync),       0);
        check({tag, "_done"},   32'(bus.update_done),     0);
        check({tag, "_err"},    32'(bus.seq_error),       0);
    endtask

    // A tick that must not start a refresh.
    task automatic no_req_tick();
        int t;
        int hi;
        hi = 0;
        do_tick(t);
        repeat (30) begin
            if (bus.rtc_read_req === 1'b1) hi++;
            step();
        end
        check("no_req_after_tick", 32'(hi), 0);
    endtask

    // Refresh-triggering tick; busy held for the first 'busy' REQ cycles.
    task automatic req_phase(input int busy, output int t);
        int hi;
        int at;
        hi = 0;
        at = -1;
        do_tick(t);
        for (int c = 1; c <= busy + 5; c++) begin
            bus.rtc_busy = (c <= busy);
            if (bus.rtc_read_req === 1'b1) begin
                hi++;
                if (at < 0) at = c;
            end
            step();
        end
        bus.rtc_busy = 1'b0;
        check("req_pulse_count", 32'(hi), 1);
        check("req_latency", at, busy + 2);
    endtask

    task automatic send_bytes(input vec_t v);
        for (int i = 0; i < v.n_bytes; i++) begin
            bus.rtc_dato_valid = 1'b1;
            bus.rtc_dato       = v.bytes[i];
            if (i == 7 && v.tick_on_last) bus.frame_tick = 1'b1;
            if (v.n_bytes == 8) sb_q.push_back(v.bytes[i]);
            step();
            bus.rtc_dato_valid = 1'b0;
            bus.frame_tick     = 1'b0;
            bus.rtc_dato       = 8'hEE;
            repeat (v.gap - 1) step();
        end
    endtask

    task automatic stream_check();
        int         t;
        logic [7:0] exp_d;
        check("sb_depth", 32'(sb_q.size()), 8);
        do_tick(t);
        for (int c = 1; c <= STREAM_LEN; c++) begin
            exp_d = 8'h00;
            if (c > LEAD && c <= LEAD + 8 && sb_q.size() > 0) exp_d = sb_q.pop_front();
            if (c == LEAD + TAIL + 9) exp_err = 1'b0;
            check($sformatf("inicio_c%0d", c), 32'(bus.inicioSecuencia), 32'(c <= LEAD + TAIL + 8));
            check($sformatf("dato_c%0d", c),   32'(bus.datoRTC),         32'(exp_d));
            check($sformatf("sync_c%0d", c),   32'(bus.resetSync),       32'(c == LEAD + TAIL + 9));
            check($sformatf("done_c%0d", c),   32'(bus.update_done),     32'(c == LEAD + TAIL + 9));
            check($sformatf("err_c%0d", c),    32'(bus.seq_error),       32'(exp_err));
            step();
        end
    endtask

    task automatic run_vec(input vec_t v);
        int t2;
        int in0;
        int sy0;
        int hi;
        check("seq_error_start", 32'(bus.seq_error), 32'(exp_err));
        if (v.spurious) begin
            bus.rtc_dato_valid = 1'b1;
            bus.rtc_dato       = 8'hAA;
            step();
            bus.rtc_dato_valid = 1'b0;
        end
        repeat (20) step();
        no_req_tick();
        repeat (50) step();
        in0 = inicio_hi;
        sy0 = sync_hi;
        req_phase(v.busy, t2);
        send_bytes(v);
        if (v.exp_error) begin
            while (cyc < t2 + TIMEOUT) step();
            check("seq_error_before_timeout", 32'(bus.seq_error), 0);
            step();
            check("seq_error_at_timeout", 32'(bus.seq_error), 1);
            exp_err = 1'b1;
            repeat (40) step();
            check("no_inicio_on_timeout", inicio_hi - in0, 0);
            check("no_sync_on_timeout", sync_hi - sy0, 0);
        end else begin
            if (v.spurious) begin
                bus.rtc_dato_valid = 1'b1;
                bus.rtc_dato       = 8'hBB;
                step();
                bus.rtc_dato_valid = 1'b0;
            end
            hi = 0;
            repeat (6) begin
                if (bus.inicioSecuencia === 1'b1) hi++;
                step();
            end
            check("no_inicio_before_tick", 32'(hi), 0);
            stream_check();
            repeat (5) step();
        end
    endtask

    initial begin
        int t;

        vecs[0] = '{bytes: {8'd24, 8'd4, 8'd3, 8'd23, 8'd12, 8'd17, 8'd5, 8'd4},
                    n_bytes: 8, gap: 1, busy: 0, spurious: 0, tick_on_last: 0, exp_error: 0};
        vecs[1] = '{bytes: {8'd59, 8'd58, 8'd23, 8'd31, 8'd12, 8'd99, 8'd6, 8'd52},
                    n_bytes: 8, gap: 1, busy: 20, spurious: 0, tick_on_last: 0, exp_error: 0};
        vecs[2] = '{bytes: {8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 8'd77, 8'd88},
                    n_bytes: 5, gap: 1, busy: 0, spurious: 0, tick_on_last: 0, exp_error: 1};
        vecs[3] = '{bytes: {8'd0, 8'd30, 8'd9, 8'd1, 8'd2, 8'd25, 8'd3, 8'd10},
                    n_bytes: 8, gap: 3, busy: 0, spurious: 1, tick_on_last: 0, exp_error: 0};
        vecs[4] = '{bytes: {8'd45, 8'd7, 8'd18, 8'd28, 8'd2, 8'd24, 8'd1, 8'd8},
                    n_bytes: 8, gap: 1, busy: 0, spurious: 0, tick_on_last: 1, exp_error: 0};

        bus.enable         = 1'b0;
        bus.frame_tick     = 1'b0;
        bus.rtc_busy       = 1'b0;
        bus.rtc_dato_valid = 1'b0;
        bus.rtc_dato       = 8'h00;
        reset              = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b1;
        step();

        // Ticks while disabled must leave the frame count at zero.
        no_req_tick();
        bus.enable = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset while byte 3 is on datoRTC, then a full restart.
        no_req_tick();
        repeat (20) step();
        req_phase(0, t);
        send_bytes(vecs[0]);
        repeat (3) step();
        do_tick(t);
        repeat (LEAD + 3) step();
        check("dato_byte3_before_reset", 32'(bus.datoRTC), 32'(vecs[0].bytes[3]));
        reset = 1'b0;
        step();
        check_all_zero("midreset");
        reset = 1'b1;
        sb_q.delete();
        no_req_tick();
        repeat (20) step();
        req_phase(0, t);
        send_bytes(vecs[1]);
        repeat (3) step();
        stream_check();
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
